uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 / 9600-baud sender. It generalises data width, baud divider, parity mode and stop-bit count. It replaces the level "Start" input with a valid/ready handshake and adds a busy flag. It sits between a byte-producing client (CPU bridge, FIFO) and the board TX pin, clocked from the 50 MHz system clock.

Parameters:
- DIVIDER, 5208: clocks per bit (50 MHz / 9600). Legal range is 2..2^DIV_W-1.
- DIV_W, 16: width of the bit-period counter.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  word to send; sampled only on an accept.
- tx_valid  in  1  client has a word on tx_data.
- tx_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.

Behaviour:
- Reset values:
  - rst_n low forces state IDLE, tx=1, busy=0, and clears all counters.
  - The reset is asynchronous: tx goes to 1 without waiting for a clock edge.
  - tx_ready=1 once rst_n is high.
- Accept rule:
  - An accept occurs when tx_valid && tx_ready at a rising edge.
  - tx_ready=1 only in IDLE. It is a combinational decode of the state.
  - On accept: tx_data is captured into a shift register, and the parity bit is computed from the captured word.
  - tx_data changes after the accept are ignored.
- State machine (IDLE, START, DATA, PAR, STOP):
  - IDLE: tx=1. Moves to START on accept.
  - START: tx=0 for DIVIDER clocks, then moves to DATA.
  - DATA: DATA_BITS bits, LSB first, each held for DIVIDER clocks. After the last bit, moves to PAR if PARITY!=0, otherwise to STOP.
  - PAR: parity bit for DIVIDER clocks.
    - Odd parity: total number of ones in data+parity is odd.
    - Even parity: total number of ones in data+parity is even.
  - STOP: tx=1 for STOP_BITS*DIVIDER clocks, then moves to IDLE.
- Timing:
  - tx is registered.
  - Accept at edge N gives tx=0 from edge N+1.
  - Each bit is exactly DIVIDER clocks; there is no off-by-one on the first or last bit.
- busy: 1 in every state except IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIVIDER clocks.
- Back-to-back frames: if tx_valid is held high, the next accept occurs in the single IDLE cycle after STOP. The minimum gap between frames is therefore one clock of tx=1 beyond the stop bits.
- Bit counter: log2-sized. It wraps to 0 on leaving DATA and on leaving STOP.
- Period counter: counts 0..DIVIDER-1 and is cleared on every state change.
- Reset mid-frame: the frame is aborted, the data is discarded, and the block restarts in IDLE. No partial frame resumes.
- tx_valid low in IDLE: the block stays in IDLE with tx=1 indefinitely.
- Illegal state encoding: the block recovers to IDLE on the next clock with tx=1.

Decomposition:
- Shared package uart_pkg contains:
  - the state enum type (IDLE/START/DATA/PAR/STOP);
  - parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2);
  - default DIVIDER_9600=5208.
- Sub-module uart_baud_cnt: a DIV_W-bit counter with synchronous clear. It outputs a one-cycle bit_done strobe when the count reaches DIVIDER-1. The future uart_rx reuses it.

Test Plan (bench uses DIVIDER=4 unless stated):
- 8N1 send of 0xA5:
  - tx_valid pulsed one cycle → tx_ready drops next cycle.
  - tx sequence, 4 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - busy is high for exactly 40 clocks, then tx_ready=1.
- PARITY=2 (even) sending 0xA5 → parity bit=0. PARITY=1 (odd) sending 0xA5 → parity bit=1. Sending 0x01 with odd parity → parity bit=0. Frame length is 44 clocks.
- STOP_BITS=2, DATA_BITS=7, sending 0x7F → tx shows 7 data ones, then tx stays high for 8 clocks before IDLE. Frame length is 40 clocks.
- Back-to-back: tx_valid held high with 0x55 then 0xAA → the second accept occurs exactly 1 clock after the first frame's STOP ends. Both frames decode correctly from a reference bit sampler.
- Data stability: tx_data changes every cycle after the accept of 0x3C → the transmitted frame still carries 0x3C.
- Reset mid-frame:
  - rst_n pulsed low during DATA bit 3 → tx=1 asynchronously and busy=0.
  - After release, tx_ready=1 and a new 0x81 frame transmits cleanly.
- Default DIVIDER=5208 smoke test: a single bit measures 5208 clocks, i.e. 104.16 µs at 50 MHz.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the default
// 9600-baud divider for a 50 MHz clock.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DIVIDER_9600 = 5208;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIVIDER-1 and strobes bit_done on the last
// count of each period. Shared between the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int DIVIDER = 5208,
    parameter int DIV_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIVIDER - 1);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity and one or two stop bits, each DIVIDER clocks wide.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DIVIDER   = DIVIDER_9600,
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_START = START;
    localparam logic [2:0] ST_DATA  = DATA;
    localparam logic [2:0] ST_PAR   = PAR;
    localparam logic [2:0] ST_STOP  = STOP;

    localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_done;
    logic                 cnt_clear;
    logic                 accept;

    // Handshake: tx_ready is high in IDLE only; a word is accepted on any
    // rising edge where tx_valid && tx_ready, and tx_data is ignored otherwise.
    assign tx_ready  = (state == ST_IDLE);
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state != ST_IDLE);
    assign cnt_clear = (state == ST_IDLE) || (state_next != state);

    uart_baud_cnt #(
        .DIVIDER (DIVIDER),
        .DIV_W   (DIV_W)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (tx_valid) state_next = ST_START;
            ST_START: if (bit_done) state_next = ST_DATA;
            ST_DATA:  if (bit_done && bit_cnt == LAST_DATA) state_next = HAS_PAR ? ST_PAR : ST_STOP;
            ST_PAR:   if (bit_done) state_next = ST_STOP;
            ST_STOP:  if (bit_done && bit_cnt == LAST_STOP) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // tx is a register of the current state, so the line lags the state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state <= state_next;

            if (accept) begin
                shreg   <= tx_data;
                par_bit <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            end else if (state == ST_DATA && bit_done) begin
                shreg <= shreg >> 1;
            end

            if ((state == ST_DATA || state == ST_STOP) && bit_done) begin
                if (state_next != state) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end

            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shreg[0];
                ST_PAR:   tx <= par_bit;
                default:  tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed frames on several parameter sets, decoded
// by a reference bit sampler and checked against an expected-frame queue.
module tb_uart_tx_param;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0, d1, d2, d4;
    logic [6:0] d3;
    logic [4:0] valid;
    logic [4:0] ready;
    logic [4:0] txs;
    logic [4:0] busy;

    // Expected frame: {instance index[2:0], parity bit, data[8:0]}
    logic [12:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param #(.DIVIDER(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(txs[0]), .busy(busy[0]));

    uart_tx_param #(.DIVIDER(4), .PARITY(2)) u_even (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(txs[1]), .busy(busy[1]));

    uart_tx_param #(.DIVIDER(4), .PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx(txs[2]), .busy(busy[2]));

    uart_tx_param #(.DIVIDER(4), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx(txs[3]), .busy(busy[3]));

    uart_tx_param u_dflt (
        .clk(clk), .rst_n(rst_n), .tx_data(d4), .tx_valid(valid[4]),
        .tx_ready(ready[4]), .tx(txs[4]), .busy(busy[4]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [8:0] v);
        case (idx)
            0:       d0 = v[7:0];
            1:       d1 = v[7:0];
            2:       d2 = v[7:0];
            3:       d3 = v[6:0];
            default: d4 = v[7:0];
        endcase
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
    endtask

    // Reference sampler for DIVIDER=4 instances: every bit must hold for 4 clocks.
    task automatic monitor(input int idx, input int db, input int par_en, input int sb);
        logic        bits [0:12];
        logic [8:0]  data;
        logic [12:0] got;
        logic [12:0] exp;
        logic        v;
        bit          stable;
        bit          stop_ok;
        bit          abort;
        int          nb;
        nb = 1 + db + par_en + sb;
        forever begin
            do @(negedge clk); while (!(rst_n === 1'b1 && txs[idx] === 1'b0));
            stable = 1'b1;
            abort  = 1'b0;
            for (int b = 0; b < nb && !abort; b++) begin
                for (int s = 0; s < 4 && !abort; s++) begin
                    if (!(b == 0 && s == 0)) @(negedge clk);
                    if (rst_n !== 1'b1) abort = 1'b1;
                    v = txs[idx];
                    if (s == 0) bits[b] = v;
                    else if (v !== bits[b]) stable = 1'b0;
                end
            end
            if (!abort) begin
                data = '0;
                for (int i = 0; i < db; i++) data[i] = bits[1 + i];
                stop_ok = 1'b1;
                for (int j = 0; j < sb; j++) if (bits[1 + db + par_en + j] !== 1'b1) stop_ok = 1'b0;
                got = {3'(idx), (par_en != 0) ? bits[1 + db] : 1'b0, data};
                check("bit_timing", 32'(stable), 1);
                check("stop_bits", 32'(stop_ok), 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_unexpected: got 0x%0h, expected no frame", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame", 32'(got), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0, 8, 0, 1);
            monitor(1, 8, 1, 1);
            monitor(2, 8, 1, 1);
            monitor(3, 7, 0, 2);
        join_none
    end

    task automatic run_frame(input int idx, input logic [8:0] d, input logic [12:0] e,
                             input int exp_len, input bit scramble);
        int blen;
        int first_low;
        @(negedge clk);
        set_data(idx, d);
        valid[idx] = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        valid[idx] = 1'b0;
        check("ready_drop", 32'(ready[idx]), 0);
        blen      = 0;
        first_low = -1;
        while (busy[idx] === 1'b1 && blen < 200) begin
            @(negedge clk);
            if (busy[idx] === 1'b1) begin
                if (txs[idx] === 1'b0 && first_low < 0) first_low = blen;
                blen++;
                if (scramble) set_data(idx, 9'($urandom_range(0, 511)));
            end
        end
        check("busy_len", blen, exp_len);
        check("tx_latency", first_low, 1);
        check("ready_back", 32'(ready[idx]), 1);
        wait_drain();
    endtask

    initial begin
        int blen;
        int gap;
        int low;
        rst_n = 1'b0;
        valid = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(txs), 32'h1F);
        check("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'h1F);

        // 8N1 0xA5, even/odd parity, 7N2
        run_frame(0, 9'h0A5, {3'd0, 1'b0, 9'h0A5}, 40, 1'b0);
        run_frame(1, 9'h0A5, {3'd1, 1'b0, 9'h0A5}, 44, 1'b0);
        run_frame(2, 9'h0A5, {3'd2, 1'b1, 9'h0A5}, 44, 1'b0);
        run_frame(2, 9'h001, {3'd2, 1'b0, 9'h001}, 44, 1'b0);
        run_frame(3, 9'h07F, {3'd3, 1'b0, 9'h07F}, 40, 1'b0);

        // Back-to-back with tx_valid held high
        @(negedge clk);
        d0 = 8'h55;
        valid[0] = 1'b1;
        exp_q.push_back({3'd0, 1'b0, 9'h055});
        @(posedge clk);
        #1;
        d0 = 8'hAA;
        exp_q.push_back({3'd0, 1'b0, 9'h0AA});
        blen = 0;
        while (busy[0] === 1'b1 && blen < 200) begin
            @(negedge clk);
            if (busy[0] === 1'b1) blen++;
        end
        check("b2b_len1", blen, 40);
        gap = 0;
        while (busy[0] !== 1'b1 && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", gap, 1);
        valid[0] = 1'b0;
        blen = 1;
        while (busy[0] === 1'b1 && blen < 200) begin
            @(negedge clk);
            if (busy[0] === 1'b1) blen++;
        end
        check("b2b_len2", blen, 40);
        wait_drain();

        // tx_data scrambled every cycle after accepting 0x3C
        run_frame(0, 9'h03C, {3'd0, 1'b0, 9'h03C}, 40, 1'b1);

        // Reset during data bit 3 of 0xE7 (bit 3 is 0), frame discarded
        @(negedge clk);
        d0 = 8'hE7;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_reset_tx", 32'(txs[0]), 0);
        check("pre_reset_busy", 32'(busy[0]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(txs[0]), 1);
        check("async_reset_busy", 32'(busy[0]), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(ready[0]), 1);
        run_frame(0, 9'h081, {3'd0, 1'b0, 9'h081}, 40, 1'b0);

        // Default divider: start bit of 0x01 must be 5208 clocks low
        @(negedge clk);
        d4 = 8'h01;
        valid[4] = 1'b1;
        @(posedge clk);
        #1;
        valid[4] = 1'b0;
        check("dflt_ready_drop", 32'(ready[4]), 0);
        low = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (txs[4] === 1'b0) low++;
            else if (low > 0) break;
        end
        check("dflt_bit_len", low, 5208);

        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
